pp_row_sequencer: RTL

//   Sequential 8x8 unsigned multiplier controller built on the partial-product AND array.

---
 rtl/pp_row_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/pp_row_sequencer.sv
// pp_row_sequencer - sequential unsigned multiplier, one partial-product row per cycle
// Operands are captured in IDLE, WIDTH rows accumulate in RUN, and the product is offered in DONE.
module pp_row_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*WIDTH-1:0]            out_prod,
  output logic                          busy,
  output logic [$clog2(WIDTH)-1:0]      row_idx
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_ROW = IW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    acc;
  logic [IW-1:0]    row_q;
  logic             valid_q;
  logic [PW-1:0]    row_ext;
  logic [PW-1:0]    row_term;

  // Row is zero-extended before the shift so no product bit is lost.
  always_comb begin
    row_ext  = {{WIDTH{1'b0}}, a_q & {WIDTH{b_q[row_q]}}};
    row_term = row_ext << row_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            acc   <= '0;
            row_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc + row_term;
          if (row_q == LAST_ROW) begin
            row_q <= '0;
            state <= DONE;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        DONE: begin
          // Product is presented one cycle after the final row lands in acc.
          if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          row_q   <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN) || (state == DONE);
  assign out_valid = valid_q;
  assign out_prod  = acc;
  assign row_idx   = row_q;

endmodule
